phase_mon_4_8: RTL

Receive-side monitor for the 4/8-phase clock bus of the SERDES clocking path. Samples the 8-bit phase word on every qualified `clk` edge and decodes the phase position. Checks that the word is a legal code for the selected mode and advances by the expected step. Reports lock, the decoded phase index, and a saturating error count to the SERDES control/status logic.

---
 rtl/phase_mon_4_8_if.sv | 23 ++
 rtl/phase_mon_4_8.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/phase_mon_4_8_if.sv
// Phase-bus monitor interface: phase word stream and mode/clear controls in,
// lock/phase/error status out to the SERDES control logic.
interface phase_mon_4_8_if;
   logic       d41_d80;
   logic       ph_vld;
   logic [7:0] ph_in;
   logic       clr_err;
   logic       lock;
   logic [2:0] phase_idx;
   logic       err_pulse;
   logic [7:0] err_cnt;
   logic [1:0] state;

   modport master (
      output d41_d80, ph_vld, ph_in, clr_err,
      input  lock, phase_idx, err_pulse, err_cnt, state
   );

   modport slave (
      input  d41_d80, ph_vld, ph_in, clr_err,
      output lock, phase_idx, err_pulse, err_cnt, state
   );
endinterface

// File: rtl/phase_mon_4_8.sv
// Receive-side monitor for the 4/8-phase clock bus: decodes each qualified
// phase word, checks legality and step, tracks lock and counts errors.
module phase_mon_4_8 #(
   parameter int STEP       = 2,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 2
) (
   input  logic           clk,
   input  logic           RESET,
   phase_mon_4_8_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACQ  = 2'd1;
   localparam logic [1:0] LOCK = 2'd2;
   localparam logic [1:0] LOST = 2'd3;

   localparam logic [2:0] STEP_W   = 3'(STEP);
   localparam logic [3:0] LOCK_W   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_W = 4'(UNLOCK_CNT);

   // {legal, index} of a 4-bit Johnson position
   function automatic logic [3:0] jdec(input logic [3:0] n);
      case (n)
         4'b0000: jdec = {1'b1, 3'd0};
         4'b0001: jdec = {1'b1, 3'd1};
         4'b0011: jdec = {1'b1, 3'd2};
         4'b0111: jdec = {1'b1, 3'd3};
         4'b1111: jdec = {1'b1, 3'd4};
         4'b1110: jdec = {1'b1, 3'd5};
         4'b1100: jdec = {1'b1, 3'd6};
         4'b1000: jdec = {1'b1, 3'd7};
         default: jdec = 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] word_dec(input logic [7:0] w, input logic m);
      logic [3:0] j;
      j = jdec(w[3:0]);
      if (m)
         word_dec = {(w[7:4] == 4'h0) && (w[3:0] == 4'h0 || w[3:0] == 4'hF), 2'b00, w[0]};
      else
         word_dec = {(w[7:4] == ~w[3:0]) && j[3], j[2:0]};
   endfunction

   logic       mode_q;
   logic       s2_vld;
   logic       v_cur, v_prev;
   logic [7:0] w_cur, w_prev;
   logic [3:0] good_cnt, bad_cnt, good_d, bad_d;
   logic [1:0] state_q, state_d;
   logic [2:0] idx_q;
   logic       err_pulse_q;
   logic [7:0] err_cnt_q;

   logic       mode_chg, cmp_en, step_ok, good, counted;
   logic [3:0] dec_cur, dec_prev;

   // mode_q is the one-flop sampled mode; any difference means a fresh start
   assign mode_chg = bus.d41_d80 != mode_q;
   assign dec_cur  = word_dec(w_cur, mode_q);
   assign dec_prev = word_dec(w_prev, mode_q);
   assign cmp_en   = s2_vld & v_cur & v_prev;
   assign step_ok  = mode_q ? (w_cur[3:0] == ~w_prev[3:0])
                            : (dec_cur[2:0] == dec_prev[2:0] + STEP_W);
   assign good     = dec_cur[3] & dec_prev[3] & step_ok;
   assign counted  = cmp_en & ~good & ~mode_chg & ((state_q == LOCK) | (state_q == LOST));

   always_comb begin
      state_d = state_q;
      good_d  = good_cnt;
      bad_d   = bad_cnt;
      if (mode_chg) begin
         state_d = ACQ;
         good_d  = 4'd0;
         bad_d   = 4'd0;
      end else if (s2_vld) begin
         case (state_q)
            IDLE: state_d = ACQ;
            ACQ: begin
               if (cmp_en) begin
                  if (!good) begin
                     good_d = 4'd0;
                  end else if (good_cnt + 4'd1 == LOCK_W) begin
                     state_d = LOCK;
                     good_d  = 4'd0;
                     bad_d   = 4'd0;
                  end else begin
                     good_d = good_cnt + 4'd1;
                  end
               end
            end
            LOCK: begin
               if (cmp_en) begin
                  if (good) begin
                     bad_d = 4'd0;
                  end else if (bad_cnt + 4'd1 == UNLOCK_W) begin
                     state_d = LOST;
                     good_d  = 4'd0;
                     bad_d   = 4'd0;
                  end else begin
                     bad_d = bad_cnt + 4'd1;
                  end
               end
            end
            default: begin
               state_d = ACQ;
               good_d  = 4'd0;
               bad_d   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         mode_q      <= 1'b0;
         s2_vld      <= 1'b0;
         v_cur       <= 1'b0;
         v_prev      <= 1'b0;
         w_cur       <= 8'h00;
         w_prev      <= 8'h00;
         good_cnt    <= 4'd0;
         bad_cnt     <= 4'd0;
         state_q     <= IDLE;
         idx_q       <= 3'd0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= 8'd0;
      end else begin
         mode_q      <= bus.d41_d80;
         state_q     <= state_d;
         good_cnt    <= good_d;
         bad_cnt     <= bad_d;
         err_pulse_q <= counted;
         // a clear coinciding with a counted error leaves exactly that error
         if (bus.clr_err)
            err_cnt_q <= {7'd0, counted};
         else if (counted && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
         if (mode_chg) begin
            s2_vld <= 1'b0;
            v_cur  <= 1'b0;
            v_prev <= 1'b0;
         end else begin
            s2_vld <= bus.ph_vld;
            if (bus.ph_vld) begin
               w_cur  <= bus.ph_in;
               w_prev <= w_cur;
               v_cur  <= 1'b1;
               v_prev <= v_cur;
            end
            if (s2_vld && dec_cur[3])
               idx_q <= dec_cur[2:0];
         end
      end
   end

   assign bus.lock      = state_q == LOCK;
   assign bus.state     = state_q;
   assign bus.phase_idx = idx_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_cnt   = err_cnt_q;
endmodule
